rca_wide_seq: RTL
=================

Name: rca_wide_seq

Overview:
- Multi-cycle sequencer that computes a WIDTH-bit addition by time-multiplexing one 4-bit ripple-carry adder (rca) instance, 4 bits per cycle, LSB chunk first.
- Holds the operand and result shift registers, the inter-chunk carry register and the chunk counter.
- Sits between a requester (valid/ready) and a consumer (valid/ready). It trades latency for area versus a full-width ripple chain.

Parameters:
- WIDTH, 16: operand/result width in bits. Must be a multiple of 4 and at least 4; any other value is an elaboration error.
- NCHUNK, WIDTH/4: derived localparam giving the number of rca passes per operation. Not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in to bit 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- Sum  output  WIDTH  result
- Cout  output  1  carry-out of the MSB
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; operand, result, carry and counter registers clear to 0.
  - Outputs: in_ready=1, out_valid=0, busy=0, Sum=0, Cout=0.
  - Reset asserted mid-RUN or mid-DONE aborts the operation; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready at a clock edge, the block latches A and B into the operand shift registers, loads the carry register with Cin, clears the counter and goes to RUN.
- RUN:
  - in_ready=0. in_valid, A, B and Cin are ignored.
  - Each cycle, the rca receives operand bits [3:0] and the carry register.
  - At the edge:
    - the rca Sum shifts into the top 4 bits of the result register (shift right by 4);
    - the operand registers shift right by 4;
    - the carry register takes the rca Cout;
    - the counter increments.
  - When the counter equals NCHUNK-1 at the edge, the FSM goes to DONE.
- DONE:
  - out_valid=1. Sum equals the result register and Cout equals the carry register.
  - Sum and Cout stay stable while out_valid=1 && out_ready=0, for any number of cycles.
  - When out_ready=1 at the edge, the FSM goes to IDLE. out_valid drops and in_ready rises on the same edge.
- Latency: if the request is accepted at edge t, out_valid=1 from edge t+NCHUNK. For WIDTH=16, that is 4 cycles.
- Throughput: a new request cannot be accepted in the cycle the result is consumed. The minimum period is NCHUNK+2 cycles with out_ready tied high.
- Arithmetic:
  - {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1).
  - The carry propagates chunk to chunk only through the carry register; there is no combinational path from chunk to chunk.
- WIDTH=4 (NCHUNK=1): RUN lasts exactly one cycle.
- out_ready high outside DONE has no effect. in_valid held high through a whole operation starts the next operation only after the FSM has returned to IDLE.

Optional Feature:
- Macro: RCA_WIDE_SEQ_SUB_EN.
- Defined:
  - Adds an input port sub (1 bit), sampled together with A and B at acceptance.
  - When sub=1, the block latches ~B into the B register and loads the carry register with 1; Cin is ignored.
  - Result: {Cout,Sum} = A + ~B + 1, so Cout=1 means no borrow.
  - When sub=0, behaviour is identical to the undefined build.
- Undefined: there is no sub port and the block always adds.

Test Plan:
- WIDTH=16: A=0x1234, B=0x1111, Cin=0 accepted at edge t -> out_valid=1 from edge t+4, Sum=0x2345, Cout=0; in_ready=0 during edges t+1..t+4.
- WIDTH=16: A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1 (carry crosses all 4 chunks). A=0xFFFF, B=0x0000, Cin=1 -> same result.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> Sum, Cout and out_valid stable. Raise out_ready -> exactly one transfer, then in_ready=1 next cycle.
- Change A/B and pulse in_valid during RUN -> the result still reflects the originally accepted operands (0x1234+0x1111=0x2345).
- Assert rst_n=0 asynchronously in the 2nd RUN cycle -> out_valid=0, Sum=0, in_ready=1 immediately. A fresh request 0x0003+0x0004 then gives 0x0007.
- RCA_WIDE_SEQ_SUB_EN defined, sub=1: A=0x0005, B=0x0007 -> Sum=0xFFFE, Cout=0. A=0x0007, B=0x0005 -> Sum=0x0002, Cout=1.

Source files
------------

// File: rtl/rca_wide_seq.sv
// rca_wide_seq: WIDTH-bit adder built from one 4-bit ripple-carry adder that
// is reused once per 4-bit chunk, LSB chunk first. The carry between chunks is
// held in a register, so there is no combinational path from one chunk to the
// next.
//
// Optional build macro: RCA_WIDE_SEQ_SUB_EN adds a 'sub' input. When sub=1 the
// block computes A + ~B + 1 (Cout=1 means no borrow).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   sub        (RCA_WIDE_SEQ_SUB_EN only) subtract select, sampled at acceptance
//   in_valid   request valid
//   in_ready   block can accept a request (IDLE)
//   A, B       WIDTH-bit operands
//   Cin        carry-in to bit 0
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts the result
//   Sum        WIDTH-bit result, zero unless out_valid
//   Cout       carry-out of the MSB, zero unless out_valid
//   busy       high in RUN or DONE
//
// States:
//   IDLE | waiting for a request, in_ready=1
//   RUN  | one 4-bit chunk added per cycle
//   DONE | result presented until out_ready

module rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[4];
  end
endmodule

module rca_wide_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef RCA_WIDE_SEQ_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             busy
);
  localparam int NCHUNK = WIDTH / 4;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("rca_wide_seq: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [3:0]       rca_sum;
  logic             rca_cout;
  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;

`ifdef RCA_WIDE_SEQ_SUB_EN
  assign b_load   = sub ? ~B : B;
  assign cin_load = sub ? 1'b1 : Cin;
`else
  assign b_load   = B;
  assign cin_load = Cin;
`endif

  rca u_rca (
    .a    (op_a[3:0]),
    .b    (op_b[3:0]),
    .cin  (carry),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  // New chunk enters at the top; after NCHUNK passes the LSB chunk has
  // arrived at bit 0.
  always_comb begin
    result_next = result >> 4;
    result_next[WIDTH-1 -: 4] = rca_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      result    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a     <= A;
            op_b     <= b_load;
            carry    <= cin_load;
            result   <= '0;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          op_a   <= op_a >> 4;
          op_b   <= op_b >> 4;
          result <= result_next;
          carry  <= rca_cout;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Gate outputs so intermediate chunks never appear on Sum/Cout.
  assign Sum  = out_valid ? result : '0;
  assign Cout = out_valid & carry;

endmodule
